// File: rtl/fp_matrix_pkg.sv
// fp_matrix_pkg: types and constants shared by fp_matrix_loader, fp32_is_special and fp_matrix.
//   fp32_t      : raw IEEE-754 single-precision word
//   FP32_EXP_*  : position and all-ones value of the exponent field
//   ld_state_e  : loader FSM states (LOAD_A, LOAD_B, HOLD)
//   fp32_exp()  : helper that extracts the biased exponent field
package fp_matrix_pkg;

  typedef logic [31:0] fp32_t;

  localparam int          FP32_EXP_MSB = 30;
  localparam int          FP32_EXP_LSB = 23;
  localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } ld_state_e;

  function automatic logic [7:0] fp32_exp(input fp32_t x);
    return x[FP32_EXP_MSB:FP32_EXP_LSB];
  endfunction

endpackage

// File: rtl/fp32_is_special.sv
// fp32_is_special: combinational Inf/NaN detector for one FP32 word.
// Ports:
//   value      in  32  FP32 word
//   is_special out 1   1 when the exponent field is all ones (Inf or NaN)
module fp32_is_special
  import fp_matrix_pkg::*;
(
  input  logic [31:0] value,
  output logic        is_special
);

  assign is_special = (fp32_exp(value) == FP32_EXP_MAX);

endmodule

// File: rtl/fp_matrix_loader.sv
// fp_matrix_loader: collects a row-major A matrix followed by a row-major B
// matrix from an FP32 valid/ready stream, then presents both as packed buses
// with a valid/ready handoff. Operands stay frozen until accepted.
// Optional build macro: FP_LOAD_CHECK_EN enables the sticky Inf/NaN flag
// elem_err; without it elem_err is tied low and no classifier exists.
// Ports:
//   clk        in   1          rising-edge clock
//   reset      in   1          synchronous active-high reset
//   flush      in   1          synchronous abort back to LOAD_A (buffers kept)
//   in_valid   in   1          upstream element valid
//   in_ready   out  1          loader can accept an element (registered)
//   in_data    in   32         FP32 element
//   a_out      out  M*N x 32   packed A, index row*N+col
//   b_out      out  N*P x 32   packed B, index row*P+col
//   mat_valid  out  1          operand pair complete and stable
//   mat_ready  in   1          consumer accepts the pair
//   elem_err   out  1          sticky Inf/NaN flag for the current pair
module fp_matrix_loader
  import fp_matrix_pkg::*;
#(
  parameter int M = 2,
  parameter int N = 2,
  parameter int P = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_data,
  output logic [0:M*N-1][31:0]    a_out,
  output logic [0:N*P-1][31:0]    b_out,
  output logic                    mat_valid,
  input  logic                    mat_ready,
  output logic                    elem_err
);

  localparam int A_CNT  = M * N;
  localparam int B_CNT  = N * P;
  localparam int MAX_E  = (A_CNT > B_CNT) ? A_CNT : B_CNT;
  localparam int IDX_W  = (MAX_E > 1) ? $clog2(MAX_E) : 1;

  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] A_LAST   = IDX_W'(A_CNT - 1);
  localparam logic [IDX_W-1:0] B_LAST   = IDX_W'(B_CNT - 1);

  ld_state_e                state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [0:A_CNT-1][31:0]   a_q, a_d;
  logic [0:B_CNT-1][31:0]   b_q, b_d;
  logic                     mat_valid_q, mat_valid_d;
  logic                     in_ready_q, in_ready_d;
  logic                     accept_s;

  // in_ready is a flop, so accept never depends combinationally on itself
  assign accept_s = in_valid & in_ready_q;

`ifdef FP_LOAD_CHECK_EN
  logic special_s;
  logic elem_err_q, elem_err_d;

  fp32_is_special u_is_special (
    .value      (in_data),
    .is_special (special_s)
  );
`endif

  // Next-state logic: flush overrides everything, then per-state load/handoff
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    mat_valid_d = mat_valid_q;
    in_ready_d  = in_ready_q;
`ifdef FP_LOAD_CHECK_EN
    elem_err_d  = elem_err_q;
`endif
    if (flush) begin
      // Element or handoff in the same cycle is discarded; buffers keep contents
      state_d     = LOAD_A;
      idx_d       = IDX_ZERO;
      mat_valid_d = 1'b0;
      in_ready_d  = 1'b1;
`ifdef FP_LOAD_CHECK_EN
      elem_err_d  = 1'b0;
`endif
    end else begin
`ifdef FP_LOAD_CHECK_EN
      elem_err_d = elem_err_q | (accept_s & special_s);
`endif
      case (state_q)
        LOAD_A: begin
          if (accept_s) begin
            a_d[idx_q] = in_data;
            if (idx_q == A_LAST) begin
              state_d = LOAD_B;
              idx_d   = IDX_ZERO;
            end else begin
              idx_d = idx_q + IDX_ONE;
            end
          end else begin
            idx_d = idx_q;
          end
        end
        LOAD_B: begin
          if (accept_s) begin
            b_d[idx_q] = in_data;
            if (idx_q == B_LAST) begin
              state_d     = HOLD;
              idx_d       = IDX_ZERO;
              mat_valid_d = 1'b1;
              in_ready_d  = 1'b0;
            end else begin
              idx_d = idx_q + IDX_ONE;
            end
          end else begin
            idx_d = idx_q;
          end
        end
        HOLD: begin
          if (mat_valid_q && mat_ready) begin
            state_d     = LOAD_A;
            idx_d       = IDX_ZERO;
            mat_valid_d = 1'b0;
            in_ready_d  = 1'b1;
`ifdef FP_LOAD_CHECK_EN
            elem_err_d  = 1'b0;
`endif
          end else begin
            mat_valid_d = 1'b1;
          end
        end
        default: begin
          state_d     = LOAD_A;
          idx_d       = IDX_ZERO;
          mat_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      endcase
    end
  end

  // State, counter, operand buffers and handshake flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD_A;
      idx_q       <= IDX_ZERO;
      a_q         <= {(A_CNT*32){1'b0}};
      b_q         <= {(B_CNT*32){1'b0}};
      mat_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mat_valid_q <= mat_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

`ifdef FP_LOAD_CHECK_EN
  // Sticky Inf/NaN flag for the pair being assembled
  always_ff @(posedge clk) begin
    if (reset) begin
      elem_err_q <= 1'b0;
    end else begin
      elem_err_q <= elem_err_d;
    end
  end

  assign elem_err = elem_err_q;
`else
  assign elem_err = 1'b0;
`endif

  assign in_ready  = in_ready_q;
  assign mat_valid = mat_valid_q;
  assign a_out     = a_q;
  assign b_out     = b_q;

endmodule
